// File: rtl/xor4_rr_sched_pkg.sv
// Shared definitions for the round-robin XOR scheduler:
// datapath width, FSM state encoding, latched operand payload, ID width helper.
package xor4_rr_sched_pkg;

    localparam int unsigned W = 4;

    // 2'b11 is not a legal state; the FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COMPUTE = 2'b01,
        HOLD    = 2'b10
    } state_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } operand_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned idw_f(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/XOr2x4.sv
// Existing 4-bit two-input XOR array cell.
// Ports: a, b - operands; y - a ^ b.
module XOr2x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor4_rr_sched_rr_pick.sv
// Combinational round-robin priority picker.
// Ports: req - request vector; ptr - highest-priority index;
//        idx - granted index; onehot - grant one-hot; any - some request is set.
module xor4_rr_sched_rr_pick #(
    parameter int unsigned N   = 2,
    parameter int unsigned IDW = 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] idx,
    output logic [N-1:0]   onehot,
    output logic           any
);

    int   hi;
    int   lo;
    logic hi_any;
    logic lo_any;

    // Lowest request at or above ptr wins; otherwise wrap to the lowest request overall.
    always_comb begin
        hi     = 0;
        lo     = 0;
        hi_any = 1'b0;
        lo_any = 1'b0;
        idx    = '0;
        onehot = '0;
        any    = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo     = i;
                lo_any = 1'b1;
                if (i >= int'(ptr)) begin
                    hi     = i;
                    hi_any = 1'b1;
                end
            end
        end
        any = lo_any;
        idx = hi_any ? IDW'(hi) : IDW'(lo);
        for (int i = 0; i < int'(N); i++) begin
            onehot[i] = any && (int'(idx) == i);
        end
    end

endmodule

// File: rtl/xor4_rr_sched.sv
// Round-robin scheduler sharing one 4-bit XOR datapath among N requesters.
// Ports: CLK, RESETN (async, active low);
//        REQ_VALID/REQ_READY/REQ_A/REQ_B - per-requester operand handshake (W bits per lane);
//        RES_VALID/RES_READY/RES_DATA/RES_ID - registered result with winner index;
//        BUSY - FSM not in IDLE.
module xor4_rr_sched
    import xor4_rr_sched_pkg::*;
#(
    parameter  int unsigned N   = 2,
    localparam int unsigned IDW = idw_f(N)
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [N-1:0]     REQ_VALID,
    output logic [N-1:0]     REQ_READY,
    input  logic [N*W-1:0]   REQ_A,
    input  logic [N*W-1:0]   REQ_B,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [W-1:0]     RES_DATA,
    output logic [IDW-1:0]   RES_ID,
    output logic             BUSY
);

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] gid;
    logic [IDW-1:0] gid_nxt;
    operand_t       ops;
    operand_t       ops_nxt;
    logic           res_valid_nxt;
    logic [W-1:0]   res_data_nxt;
    logic [IDW-1:0] res_id_nxt;

    logic [IDW-1:0] pick_idx;
    logic [N-1:0]   pick_onehot;
    logic           pick_any;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [W-1:0]   xor_y;

    xor4_rr_sched_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (REQ_VALID),
        .ptr    (ptr),
        .idx    (pick_idx),
        .onehot (pick_onehot),
        .any    (pick_any)
    );

    XOr2x4 u_xor (
        .a (ops.a),
        .b (ops.b),
        .y (xor_y)
    );

    // Operand mux for the current winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (pick_onehot[i]) begin
                sel_a = REQ_A[i*W +: W];
                sel_b = REQ_B[i*W +: W];
            end
        end
    end

    // Next-state and handshake logic.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        gid_nxt       = gid;
        ops_nxt       = ops;
        res_valid_nxt = RES_VALID;
        res_data_nxt  = RES_DATA;
        res_id_nxt    = RES_ID;
        REQ_READY     = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    // Gated so no grant can leak out while reset is held.
                    REQ_READY = RESETN ? pick_onehot : '0;
                    ops_nxt   = '{a: sel_a, b: sel_b};
                    gid_nxt   = pick_idx;
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                res_data_nxt  = xor_y;
                res_id_nxt    = gid;
                res_valid_nxt = 1'b1;
                state_nxt     = HOLD;
            end
            HOLD: begin
                if (RES_READY) begin
                    res_valid_nxt = 1'b0;
                    ptr_nxt       = (gid == IDW'(N - 1)) ? '0 : gid + 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                res_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= IDLE;
            ptr       <= '0;
            gid       <= '0;
            ops       <= '0;
            RES_VALID <= 1'b0;
            RES_DATA  <= '0;
            RES_ID    <= '0;
            BUSY      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gid       <= gid_nxt;
            ops       <= ops_nxt;
            RES_VALID <= res_valid_nxt;
            RES_DATA  <= res_data_nxt;
            RES_ID    <= res_id_nxt;
            BUSY      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: doc/xor4_rr_sched.md
Name: xor4_rr_sched

Overview:
- Round-robin scheduler that shares one 4-bit two-operand XOR datapath (the existing XOr2x4 cell) among N requesters.
- Each requester offers an operand pair over a valid/ready handshake.
- The scheduler grants one requester, sequences the operands through the XOR unit, and holds the registered result with the winner's ID until the consumer accepts it.
- Sits between board-level input nibbles and any result sink on the ice40 target.

Parameters:
- N, 2, number of requesters (1..8).
- W, 4, operand/result width; fixed to the XOR datapath width.
- IDW, max(1, clog2(N)), width of RES_ID.

Ports:
- CLK  in  1  system clock, rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- REQ_VALID  in  N  bit i: requester i presents an operand pair.
- REQ_READY  out  N  bit i: requester i's pair is accepted this cycle (one-hot or zero).
- REQ_A  in  N*W  operand A; requester i occupies bits [i*W+W-1 : i*W].
- REQ_B  in  N*W  operand B; same packing as REQ_A.
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer accepts the result.
- RES_DATA  out  W  A xor B for the granted requester.
- RES_ID  out  IDW  index of the requester that produced RES_DATA.
- BUSY  out  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset: single clock CLK; reset is asynchronous and active-low on RESETN. All state registers use async clear.
- Reset values:
  - state=IDLE, ptr=0, RES_VALID=0, RES_DATA=0, RES_ID=0, BUSY=0.
  - Operand registers are cleared to 0.
  - REQ_READY=0 while RESETN is low.
- FSM, states IDLE, COMPUTE, HOLD:
  - IDLE: if any REQ_VALID is high, grant g = first set bit searching upward from ptr, wrapping at N-1 -> 0. REQ_READY[g] is driven high combinationally in that cycle. At the clock edge, latch REQ_A[g], REQ_B[g] and g, then go to COMPUTE. With no request, stay in IDLE.
  - COMPUTE: feed the latched operands to the XOR unit. At the edge, register RES_DATA = A^B and RES_ID = g, set RES_VALID=1, go to HOLD.
  - HOLD: RES_VALID, RES_DATA and RES_ID stay stable. When RES_READY=1 at an edge:
    - RES_VALID -> 0
    - ptr -> (g+1) mod N
    - state -> IDLE.
- REQ_READY is zero in COMPUTE and HOLD. A requester must hold REQ_VALID and its operands until it sees REQ_READY.
- Latency: handshake at edge t gives RES_VALID high after edge t+1. Minimum initiation interval is 3 cycles: accept, compute, hold/ack.
- RES_READY is ignored outside HOLD. RES_READY held high permanently gives exactly one ack per result.
- Fairness: with all N requesters continuously valid, grants rotate 0,1,...,N-1,0. Max wait is N-1 transactions.
- Single active requester: it is granted every transaction regardless of ptr.
- ptr wraps N-1 -> 0. For N=1, ptr is constantly 0 and RES_ID=0.
- A requester dropping REQ_VALID in the cycle it is granted is a protocol violation; the bench checks that this never happens.
- Reset mid-operation (COMPUTE or HOLD): the in-flight result is discarded and RES_VALID drops immediately (async). No REQ_READY pulses until reset is released and the FSM is back in IDLE.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'b00, COMPUTE=2'b01, HOLD=2'b10; 2'b11 is illegal and recovers to IDLE.
  - W=4.
  - IDW helper function.
- Sub-module rr_pick: combinational round-robin priority picker. Inputs are request vector (N) and ptr; outputs are grant index, grant one-hot and any. Reused by future arbiters.
- The XOR datapath is an instance of the existing 4-bit two-input XOR array. It is not re-implemented.

Test Plan:
- Reset then idle: RESETN low for 2 cycles, no requests -> RES_VALID=0, REQ_READY=0, BUSY=0, RES_DATA=0 throughout.
- Single request:
  - Stimulus: REQ_VALID=2'b01, A0=4'hA, B0=4'h3.
  - Required: REQ_READY=2'b01 in cycle 0; RES_VALID high after edge 1; RES_DATA=4'h9, RES_ID=0; held stable for 3 cycles with RES_READY=0.
  - Then RES_READY=1 for one cycle -> RES_VALID=0 next cycle.
- Contention:
  - Stimulus: both valid continuously, A0^B0=4'hF^4'h0, A1^B1=4'h5^4'h5, RES_READY=1.
  - Required: results alternate ID0/4'hF, ID1/4'h0, ID0, ID1; one accept every 3 cycles.
- Pointer wrap: N=3, requesters 2 and 0 valid, ptr=2 -> grant 2 first, then 0; RES_ID sequence 2,0.
- Backpressure: RES_READY=0 for 10 cycles while both requesters are valid -> no further REQ_READY; RES_DATA/RES_ID unchanged; BUSY=1.
- Async reset in HOLD: assert RESETN=0 mid-cycle -> RES_VALID and BUSY drop before the next clock edge. After release, the next request is granted from ptr=0.
